// File: rtl/ddr_prog_dly_se_cfg_seq.sv
// ddr_prog_dly_se_cfg_seq: glitch-safe config sequencer for a single-ended
// programmable delay cell. Walks the code one LSB at a time while enabled,
// otherwise runs a disable / reload / re-enable sequence.
// Ports: i_clk, i_rst (sync, high); i_req/i_ctrl/i_gear/i_ena target request;
// o_ready (idle), o_ack (1-cycle done), o_prog_dly_cfg {gear, ena, code}.
module ddr_prog_dly_se_cfg_seq #(
  parameter int CTRL_W     = 6,
  parameter int GEAR_W     = 2,
  parameter int PWIDTH     = 9,
  parameter int SETTLE_CYC = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [GEAR_W-1:0] i_gear,
  input  logic              i_ena,
  output logic              o_ready,
  output logic              o_ack,
  output logic [PWIDTH-1:0] o_prog_dly_cfg
);

  if (PWIDTH != CTRL_W + 1 + GEAR_W) begin : g_bad_pwidth
    $error("PWIDTH must equal CTRL_W+1+GEAR_W");
  end
  if (SETTLE_CYC < 1 || SETTLE_CYC > 255) begin : g_bad_settle
    $error("SETTLE_CYC must be in 1..255");
  end

  typedef enum logic [2:0] {
    IDLE, WALK, WAIT, DIS, LOAD, EN, ACK
  } state_t;

  localparam logic [7:0] SETTLE_M1 = 8'(SETTLE_CYC - 1);
  localparam logic [CTRL_W-1:0] CODE_ONE = CTRL_W'(1);

  state_t st_q, st_d;
  logic [PWIDTH-1:0] cfg_q, cfg_d;
  logic [7:0] cnt_q, cnt_d;
  logic [CTRL_W-1:0] tcode_q, tcode;
  logic [GEAR_W-1:0] tgear_q, tgear;
  logic tena_q, tena;
  logic reload_q, reload_d;
  logic loaded_q, loaded_d;
  logic [CTRL_W-1:0] cur_code;
  logic [GEAR_W-1:0] cur_gear;
  logic cur_ena;
  logic idle, walk_ok, is_reload, ld, decide;

  assign cur_code = cfg_q[CTRL_W-1:0];
  assign cur_ena  = cfg_q[CTRL_W];
  assign cur_gear = cfg_q[PWIDTH-1:CTRL_W+1];

  // In IDLE the decision uses the live request; afterwards the latched one.
  assign idle  = (st_q == IDLE);
  assign tcode = idle ? i_ctrl : tcode_q;
  assign tgear = idle ? i_gear : tgear_q;
  assign tena  = idle ? i_ena : tena_q;

  assign walk_ok   = cur_ena & tena & (cur_gear == tgear);
  assign is_reload = idle ? ~walk_ok : reload_q;
  assign ld        = idle ? 1'b0 : loaded_q;

  // Each write state is the first settle cycle; WAIT covers the rest.
  always_comb begin
    st_d     = st_q;
    cfg_d    = cfg_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    loaded_d = loaded_q;
    decide   = 1'b0;
    unique case (st_q)
      IDLE: decide = i_req;
      ACK:  st_d = IDLE;
      WALK, WAIT, DIS, LOAD, EN: begin
        if (cnt_q == 8'd0) begin
          decide = 1'b1;
        end else begin
          st_d  = WAIT;
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: st_d = IDLE;
    endcase
    if (decide) begin
      cnt_d    = SETTLE_M1;
      reload_d = is_reload;
      loaded_d = ld;
      if (idle && cfg_q == {tgear, tena, tcode}) begin
        st_d  = ACK;
        cnt_d = 8'd0;
      end else if (!is_reload && cur_code == tcode) begin
        st_d  = ACK;
        cnt_d = 8'd0;
      end else if (!is_reload) begin
        st_d = WALK;
        cfg_d[CTRL_W-1:0] = (tcode > cur_code) ?
                            cur_code + CODE_ONE :
                            cur_code - CODE_ONE;
      end else if (!ld) begin
        if (cur_ena) begin
          st_d          = DIS;
          cfg_d[CTRL_W] = 1'b0;
        end else begin
          st_d     = LOAD;
          cfg_d    = {tgear, 1'b0, tcode};
          loaded_d = 1'b1;
        end
      end else if (tena && !cur_ena) begin
        st_d          = EN;
        cfg_d[CTRL_W] = 1'b1;
      end else begin
        st_d  = ACK;
        cnt_d = 8'd0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      st_q     <= IDLE;
      cfg_q    <= '0;
      cnt_q    <= '0;
      reload_q <= 1'b0;
      loaded_q <= 1'b0;
      tcode_q  <= '0;
      tgear_q  <= '0;
      tena_q   <= 1'b0;
    end else begin
      st_q     <= st_d;
      cfg_q    <= cfg_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      loaded_q <= loaded_d;
      if (idle && i_req) begin
        tcode_q <= i_ctrl;
        tgear_q <= i_gear;
        tena_q  <= i_ena;
      end
    end
  end

  assign o_ready        = idle;
  assign o_ack          = (st_q == ACK);
  assign o_prog_dly_cfg = cfg_q;

endmodule

// File: tb/tb_ddr_prog_dly_se_cfg_seq.sv
// tb_ddr_prog_dly_se_cfg_seq: directed vectors with a scoreboard of
// expected cfg changes and acks, checked by an independent monitor.
module tb_ddr_prog_dly_se_cfg_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       req;
  logic [5:0] ctrl;
  logic [1:0] gear;
  logic       ena;
  logic       ready;
  logic       ack;
  logic [8:0] cfg;

  ddr_prog_dly_se_cfg_seq #(
    .CTRL_W(6), .GEAR_W(2), .PWIDTH(9), .SETTLE_CYC(4)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_req(req),
    .i_ctrl(ctrl),
    .i_gear(gear),
    .i_ena(ena),
    .o_ready(ready),
    .o_ack(ack),
    .o_prog_dly_cfg(cfg)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         is_ack;
    logic [8:0] val;
    int         t;
  } ev_t;

  ev_t q[$];
  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  logic [8:0] prev;

  task automatic exp_cfg(input logic [8:0] v, input int t);
    ev_t e;
    e.is_ack = 1'b0; e.val = v; e.t = t;
    q.push_back(e);
  endtask

  task automatic exp_ack(input int t);
    ev_t e;
    e.is_ack = 1'b1; e.val = 9'h000; e.t = t;
    q.push_back(e);
  endtask

  // t is the edge index at which the observed value would be sampled.
  task automatic check_ev(input bit a, input logic [8:0] v);
    ev_t e;
    int t;
    t = cyc + 1;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event got ack=%0d cfg=%h t=%0d required none",
               a, v, t);
    end else begin
      e = q.pop_front();
      if (e.is_ack != a || (!a && e.val !== v) || e.t != t) begin
        errors++;
        $display("FAIL event got ack=%0d cfg=%h t=%0d required ack=%0d cfg=%h t=%0d",
                 a, v, t, e.is_ack, e.val, e.t);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (cfg !== prev) check_ev(1'b0, cfg);
      if (ack) check_ev(1'b1, cfg);
    end
    prev = cfg;
  end

  task automatic chk(input string name, input logic [8:0] got,
                     input logic [8:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h required %h", name, got, want);
    end
  endtask

  task automatic start(input logic [5:0] c, input logic [1:0] g,
                       input logic e, output int n);
    @(negedge clk);
    chk("ready_before_req", {8'd0, ready}, 9'd1);
    ctrl = c; gear = g; ena = e; req = 1'b1;
    n = cyc + 1;
  endtask

  task automatic release_req();
    @(negedge clk);
    req  = 1'b0;
    ctrl = 6'($urandom);
    gear = 2'($urandom);
    ena  = 1'($urandom);
  endtask

  task automatic drain(input string name, input int budget);
    int k;
    k = 0;
    while (q.size() != 0 && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout pending=%0d required 0", name, q.size());
      q.delete();
    end
  endtask

  int n;

  initial begin
    rst = 1'b1; req = 1'b0; ctrl = '0; gear = '0; ena = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cfg", cfg, 9'h000);
    chk("rst_ready", {8'd0, ready}, 9'd1);
    chk("rst_ack", {8'd0, ack}, 9'd0);
    rst = 1'b0;
    mon_en = 1'b1;

    // reload from reset
    start(6'h20, 2'd2, 1'b1, n);
    exp_cfg(9'h120, n + 1); exp_cfg(9'h160, n + 5); exp_ack(n + 9);
    release_req(); drain("reload_rst", 40);

    // walk up
    start(6'h23, 2'd2, 1'b1, n);
    exp_cfg(9'h161, n + 1); exp_cfg(9'h162, n + 5);
    exp_cfg(9'h163, n + 9); exp_ack(n + 13);
    release_req(); drain("walk_up", 40);

    // walk down
    start(6'h20, 2'd2, 1'b1, n);
    exp_cfg(9'h162, n + 1); exp_cfg(9'h161, n + 5);
    exp_cfg(9'h160, n + 9); exp_ack(n + 13);
    release_req(); drain("walk_down", 40);

    // gear change while enabled
    start(6'h10, 2'd1, 1'b1, n);
    exp_cfg(9'h120, n + 1); exp_cfg(9'h090, n + 5);
    exp_cfg(9'h0D0, n + 9); exp_ack(n + 13);
    release_req(); drain("gear_chg", 40);

    // busy: mid-walk requests are ignored
    start(6'h13, 2'd1, 1'b1, n);
    exp_cfg(9'h0D1, n + 1); exp_cfg(9'h0D2, n + 5);
    exp_cfg(9'h0D3, n + 9); exp_ack(n + 13);
    release_req();
    repeat (2) @(negedge clk);
    chk("busy_ready", {8'd0, ready}, 9'd0);
    ctrl = 6'h3F; gear = 2'd0; ena = 1'b0; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    repeat (3) @(negedge clk);
    ctrl = 6'h01; gear = 2'd3; ena = 1'b1; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    drain("busy", 40);

    // NOP
    start(6'h13, 2'd1, 1'b1, n);
    exp_ack(n + 1);
    release_req(); drain("nop", 20);

    // disable, same code/gear: LOAD rewrites the same value
    start(6'h13, 2'd1, 1'b0, n);
    exp_cfg(9'h093, n + 1); exp_ack(n + 9);
    release_req(); drain("disable", 40);

    // reload from ena=0
    start(6'h05, 2'd3, 1'b1, n);
    exp_cfg(9'h185, n + 1); exp_cfg(9'h1C5, n + 5); exp_ack(n + 9);
    release_req(); drain("reload_off", 40);

    // reset during the WAIT after the second walk step
    start(6'h0A, 2'd3, 1'b1, n);
    exp_cfg(9'h1C6, n + 1); exp_cfg(9'h1C7, n + 5);
    release_req();
    while (cyc < n + 6) @(negedge clk);
    rst = 1'b1;
    exp_cfg(9'h000, n + 8);
    @(negedge clk);
    #1;
    chk("rst_mid_ready", {8'd0, ready}, 9'd1);
    chk("rst_mid_cfg", cfg, 9'h000);
    rst = 1'b0;
    drain("rst_mid", 5);
    repeat (20) @(negedge clk);

    // boundary: walk to max code
    start(6'h3E, 2'd0, 1'b1, n);
    exp_cfg(9'h03E, n + 1); exp_cfg(9'h07E, n + 5); exp_ack(n + 9);
    release_req(); drain("reload_3e", 40);
    start(6'h3F, 2'd0, 1'b1, n);
    exp_cfg(9'h07F, n + 1); exp_ack(n + 5);
    release_req(); drain("walk_max", 40);

    repeat (10) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL final_queue got %0d required 0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
